mem_arbiter: RTL and testbench

//  Shares the single-port byte-addressed big-endian memory between the instruction-fetch

---
 rtl/mem_defs.sv | 8 +
 rtl/be_merge.sv | 9 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// mem_defs: shared memory-arbiter constants, FSM state encoding and byte-mask helper
package mem_defs;
    localparam int MEM_BYTES_DEF = 1024;
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR} state_t;
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/be_merge.sv
// be_merge: combine an old memory word with new store data under a byte mask
module be_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [31:0] mask,
    output logic [31:0] merged
);
    assign merged = (old_word & ~mask) | (new_word & mask);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin IF/D arbiter sequencing read/write phases with RMW for partial stores
module mem_arbiter
    import mem_defs::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_mask,
    output logic        mem_rph,
    output logic        mem_wph,
    output logic        mem_w,
    input  logic [31:0] mem_rdata
);
    state_t      state, state_nx;
    logic        last_d, owner_d;
    logic        idle, gnt, req_we, in_range, imm, fin, fin_d;
    logic [31:0] req_addr, merged, rd_word;

    assign idle     = state == IDLE;
    assign if_gnt   = idle & ~rst & if_req & (~d_req | last_d);
    assign d_gnt    = idle & ~rst & d_req & (~if_req | ~last_d);
    assign gnt      = if_gnt | d_gnt;
    assign req_addr = d_gnt ? d_addr : if_addr;
    assign req_we   = d_gnt & d_we;
    assign in_range = req_addr <= 32'(MEM_BYTES - 4);
    assign mem_rph  = (state == RD) | (state == RMW_RD);
    assign mem_wph  = (state == WR) | (state == RMW_WR);
    assign mem_w    = mem_wph;
    assign imm      = gnt & (state_nx == IDLE);
    assign fin      = imm | (state == RD) | (state == WR) | (state == RMW_WR);
    assign fin_d    = imm ? d_gnt : owner_d;
    assign rd_word  = (state == RD) ? mem_rdata : '0;

    be_merge u_merge (
        .old_word(mem_rdata),
        .new_word(mem_wdata),
        .mask    (mem_mask),
        .merged  (merged)
    );

    // Next state: decode the granted request, otherwise step through the phase sequence
    always_comb begin
        state_nx = (state == RMW_RD) ? RMW_WR :
                   (idle && gnt && in_range && !(req_we && d_be == 4'h0)) ?
                   (!req_we ? RD : (&d_be) ? WR : RMW_RD) : IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant bookkeeping, memory-side registers and per-port response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (gnt) begin
                last_d  <= d_gnt;
                owner_d <= d_gnt;
            end
            if (gnt && state_nx != IDLE) begin
                mem_addr  <= req_addr;
                mem_wdata <= req_we ? d_wdata : '0;
                mem_mask  <= req_we ? be_mask(d_be) : '1;
            end
            if (state == RMW_RD) mem_wdata <= merged;
            if (fin && !fin_d) begin
                if_valid <= 1'b1;
                if_rdata <= rd_word;
                if_err   <= imm & ~in_range;
            end
            if (fin && fin_d) begin
                d_valid <= 1'b1;
                d_rdata <= rd_word;
                d_err   <= imm & ~in_range;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven bench with a byte-array memory model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        if_gnt, if_valid, if_err, d_gnt, d_valid, d_err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_mask, mem_rdata;
    logic        mem_rph, mem_wph, mem_w;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rph(mem_rph), .mem_wph(mem_wph), .mem_w(mem_w), .mem_rdata(mem_rdata)
    );

    logic [7:0] mem [0:1023];

    always_comb begin
        mem_rdata = '0;
        if (mem_addr <= 32'd1020)
            mem_rdata = {mem[int'(mem_addr)], mem[int'(mem_addr) + 1],
                         mem[int'(mem_addr) + 2], mem[int'(mem_addr) + 3]};
    end

    always @(posedge clk)
        if (mem_wph && mem_w && mem_addr <= 32'd1020)
            for (int i = 0; i < 4; i++)
                if (mem_mask[31 - 8 * i]) mem[int'(mem_addr) + i] <= mem_wdata[31 - 8 * i -: 8];

    int overlap = 0;
    always @(negedge clk)
        if ((mem_rph && mem_wph) || (mem_w && !mem_wph)) overlap++;

    int checks = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] peek(input int a);
        return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
    endfunction

    task automatic put_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + i] = w[31 - 8 * i -: 8];
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rph;
        int          exp_wph;
    } vec_t;

    task automatic run_vec(input vec_t t, input int idx);
        int k, lat, rph, wph, wrong;
        logic [31:0] rd;
        logic er;
        @(negedge clk);
        if_req = !t.is_d; d_req = t.is_d; if_addr = t.addr; d_addr = t.addr;
        d_we = t.we; d_wdata = t.wdata; d_be = t.be;
        #1;
        k = 0;
        while (!(t.is_d ? d_gnt : if_gnt) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d grant", idx), 32'(k < 10), 32'd1);
        if (k >= 10) begin
            if_req = 0; d_req = 0;
            return;
        end
        @(posedge clk);
        #1 if_req = 0; d_req = 0;
        lat = 0; rph = 0; wph = 0; wrong = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            rph += int'(mem_rph);
            wph += int'(mem_wph);
            if (t.is_d ? if_valid : d_valid) wrong++;
            if (t.is_d ? d_valid : if_valid) begin
                lat = c;
                rd = t.is_d ? d_rdata : if_rdata;
                er = t.is_d ? d_err : if_err;
            end
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(t.exp_lat));
        chk($sformatf("v%0d err", idx), 32'(er), 32'(t.exp_err));
        if (t.exp_lat > 1) chk($sformatf("v%0d rdata", idx), rd, t.exp_rdata);
        chk($sformatf("v%0d rph cycles", idx), 32'(rph), 32'(t.exp_rph));
        chk($sformatf("v%0d wph cycles", idx), 32'(wph), 32'(t.exp_wph));
        chk($sformatf("v%0d wrong-port valid", idx), 32'(wrong), 32'd0);
    endtask

    vec_t v[$];
    int   order[$];
    int   ifv, dv, k, wph_seen, dv_seen;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        put_word(32'h10, 32'h11223344);
        put_word(32'h3FC, 32'hCAFEF00D);
        put_word(32'h30, 32'h99887766);
        //         is_d we  addr           wdata          be     exp_rdata      err lat rph wph
        v.push_back('{1'b0, 1'b0, 32'h10,       32'h0,        4'h0, 32'h11223344, 1'b0, 2, 1, 0});
        v.push_back('{1'b1, 1'b1, 32'h10,       32'hAABBCCDD, 4'h6, 32'h0,        1'b0, 3, 1, 1});
        v.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        4'h0, 32'h11BBCC44, 1'b0, 2, 1, 0});
        v.push_back('{1'b1, 1'b0, 32'h3FD,      32'h0,        4'h0, 32'h0,        1'b1, 1, 0, 0});
        v.push_back('{1'b1, 1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 1, 0, 0});
        v.push_back('{1'b0, 1'b0, 32'h10,       32'h0,        4'h0, 32'h11BBCC44, 1'b0, 2, 1, 0});
        v.push_back('{1'b1, 1'b1, 32'h20,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 2, 0, 1});
        v.push_back('{1'b0, 1'b0, 32'h20,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0});
        v.push_back('{1'b0, 1'b0, 32'h3FC,      32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0});
        v.push_back('{1'b0, 1'b0, 32'h400,      32'h0,        4'h0, 32'h0,        1'b1, 1, 0, 0});
        v.push_back('{1'b1, 1'b1, 32'h20,       32'h55000000, 4'h8, 32'h0,        1'b0, 3, 1, 1});
        v.push_back('{1'b0, 1'b0, 32'h20,       32'h0,        4'h0, 32'h55ADBEEF, 1'b0, 2, 1, 0});
        v.push_back('{1'b1, 1'b1, 32'h3FD,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1, 0, 0});
        v.push_back('{1'b0, 1'b0, 32'h3FC,      32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0});
        v.push_back('{1'b1, 1'b1, 32'h24,       32'h000000AB, 4'h1, 32'h0,        1'b0, 3, 1, 1});
        v.push_back('{1'b1, 1'b0, 32'h24,       32'h0,        4'h0, 32'h000000AB, 1'b0, 2, 1, 0});
        v.push_back('{1'b1, 1'b0, 32'hFFFFFFFE, 32'h0,        4'h0, 32'h0,        1'b1, 1, 0, 0});

        if_req = 1; d_req = 1; if_addr = 32'h10; d_addr = 32'h10; d_we = 0;
        repeat (2) @(negedge clk);
        chk("reset gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
        chk("reset valids/errs", {28'd0, if_valid, d_valid, if_err, d_err}, 32'd0);
        chk("reset strobes", {29'd0, mem_rph, mem_wph, mem_w}, 32'd0);
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset mem_mask", mem_mask, 32'd0);

        rst = 0;
        #1;
        chk("first grant to IF", {30'd0, if_gnt, d_gnt}, 32'd2);
        ifv = 0; dv = 0;
        for (int c = 0; c < 40; c++) begin
            if (if_gnt) order.push_back(0);
            if (d_gnt) order.push_back(1);
            ifv += int'(if_valid);
            dv += int'(d_valid);
            if (order.size() >= 4) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1 if_req = 0; d_req = 0;
        repeat (4) begin
            @(negedge clk);
            ifv += int'(if_valid);
            dv += int'(d_valid);
        end
        chk("rr grant count", 32'(order.size()), 32'd4);
        if (order.size() == 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("rr grant %0d owner", i), 32'(order[i]), 32'(i % 2));
        chk("rr if_valid count", 32'(ifv), 32'd2);
        chk("rr d_valid count", 32'(dv), 32'd2);
        chk("rr if_rdata", if_rdata, 32'h11223344);
        chk("rr d_rdata", d_rdata, 32'h11223344);

        foreach (v[i]) run_vec(v[i], i);

        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h00001234; d_be = 4'h3;
        #1;
        k = 0;
        while (!d_gnt && k < 10) begin
            @(negedge clk);
            #1 k++;
        end
        chk("rmw reset grant", 32'(k < 10), 32'd1);
        @(posedge clk);
        #1 d_req = 0; rst = 1;
        @(negedge clk);
        chk("rmw reset in read phase", {30'd0, mem_rph, mem_wph}, 32'd2);
        @(posedge clk);
        #1 rst = 0;
        wph_seen = 0; dv_seen = 0;
        repeat (4) begin
            @(negedge clk);
            wph_seen += int'(mem_wph | mem_rph);
            dv_seen += int'(d_valid);
        end
        chk("rmw reset strobes", 32'(wph_seen), 32'd0);
        chk("rmw reset d_valid", 32'(dv_seen), 32'd0);
        chk("rmw reset memory", peek(32'h30), 32'h99887766);
        run_vec('{1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h99887766, 1'b0, 2, 1, 0}, 100);

        chk("phase overlap", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
